conv_result_writer: RTL and testbench
=====================================

Name: conv_result_writer

Overview:
- Downstream stage of the 3x3 dual-window convolution engine.
- Captures each result pair (two 8-bit sums, two 10-bit destination addresses) when the engine pulses done, and buffers pairs in a small FIFO.
- Serialises each pair into two writes on the single-port feature-map memory, with backpressure.
- Decouples convolution throughput from memory write availability.

Parameters:
- DEPTH, 4, pair-FIFO depth in entries (power of two, >=2)
- ADDR_W, 10, destination address width
- DATA_W, 8, sum/data width

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  result pair present (driven by convolve o_done)
- i_sum1  in  DATA_W  first-window sum
- i_sum2  in  DATA_W  second-window sum
- i_dest_addr1  in  ADDR_W  destination for i_sum1
- i_dest_addr2  in  ADDR_W  destination for i_sum2
- o_ready  out  1  FIFO not full; pair accepted when i_valid && o_ready
- o_wr_en  out  1  memory write request
- o_wr_addr  out  ADDR_W  write address
- o_wr_data  out  DATA_W  write data
- i_wr_ready  in  1  memory accepts write this cycle (o_wr_en && i_wr_ready = write done)
- o_busy  out  1  FIFO non-empty or write in progress
- o_overflow  out  1  sticky: i_valid seen while full
- o_pairs_written  out  16  count of pairs fully written, wraps at 65535->0

Behaviour:
- Reset (i_rst_n low, asynchronous): FIFO empty, state IDLE, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_overflow=0, o_pairs_written=0, o_busy=0, o_ready=1.
- All outputs are registered except o_ready and o_busy, which are combinational from count and state.
- FIFO:
  - Push on i_valid && o_ready.
  - Count width clog2(DEPTH+1); read/write pointers wrap modulo DEPTH.
  - o_ready = (count != DEPTH).
  - Push and pop in the same cycle leave count unchanged.
  - When full, a push is rejected even if a pop occurs that cycle.
- Overflow: i_valid && !o_ready sets o_overflow; cleared only by reset; the dropped pair is discarded.
- FSM, states IDLE, WR_FIRST, WR_SECOND:
  - IDLE: if count>0, pop the head into holding registers, drive o_wr_en=1, o_wr_addr=addr1, o_wr_data=sum1, go to WR_FIRST. Otherwise o_wr_en=0.
  - WR_FIRST: hold the outputs stable until i_wr_ready. On handshake, drive addr2/sum2 and go to WR_SECOND.
  - WR_SECOND: hold until i_wr_ready. On handshake, increment o_pairs_written. If count>0, pop the next pair and go straight to WR_FIRST with it (no bubble). Otherwise drop o_wr_en and go to IDLE.
- Latency: i_valid sampled at edge k into an empty FIFO gives o_wr_en high after edge k+1, with sum1. With i_wr_ready held high, sum2 follows one cycle later.
- Throughput: 1 pair per 2 cycles, which the engine cannot exceed.
- o_wr_addr and o_wr_data must not change while o_wr_en=1 && !i_wr_ready.
- Equal addr1 and addr2: both writes are issued, in order (sum2 last).
- o_busy = (count>0) || (state != IDLE).
- Reset mid-write: the write is abandoned, o_wr_en drops immediately, and FIFO contents are lost.

Optional Feature:
- Macro CONV_WB_RELU_EN.
- Defined: each sum is treated as signed two's complement before writing; values with MSB=1 are written as 0, others unchanged. Applied at pop time to the holding registers.
- Undefined: sums are written unmodified.
- The FIFO always stores raw values.

Decomposition:
- Shared package npu_pkg:
  - ADDR_W=10 and DATA_W=8 constants.
  - Writer state typedef (IDLE/WR_FIRST/WR_SECOND).
  - Result-pair struct {sum1, sum2, addr1, addr2}.
- One sub-module, result_pair_fifo: synchronous FIFO of pair structs, with push, pop, count, full and empty.
- The FSM, ReLU, and counters live in conv_result_writer.

Test Plan:
- Single pair, i_wr_ready=1: sum1=0x12@0x040, sum2=0x34@0x041 -> writes (0x040,0x12) then (0x041,0x34) on consecutive cycles, first 2 cycles after i_valid; o_pairs_written=1; o_busy low afterward.
- Backpressure: i_wr_ready low for 5 cycles during WR_FIRST -> addr/data held stable throughout, exactly 2 writes total, in order.
- Fill and overflow, DEPTH=4, i_wr_ready=0: push 5 pairs -> o_ready low after 4 plus the in-flight pop accounting; 6th i_valid sets o_overflow=1; release i_wr_ready -> the accepted pairs are written in FIFO order, dropped pair never appears.
- Back-to-back drain: 3 queued pairs, i_wr_ready=1 -> 6 consecutive write cycles, no idle gap; o_pairs_written=3.
- Async reset mid-WR_SECOND: assert i_rst_n=0 between clock edges -> o_wr_en=0 immediately, counters 0, o_ready=1, no further writes.
- CONV_WB_RELU_EN defined: sums 0xF0 and 0x7F -> written 0x00 and 0x7F; macro undefined -> 0xF0 and 0x7F.

Source files
------------

// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared widths, writer state encoding, result-pair record and
//               the ReLU clamp used by the convolution result writer.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_FIRST  = 2'd1,
        ST_WR_SECOND = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] sum1;
        logic [DATA_W-1:0] sum2;
        logic [ADDR_W-1:0] addr1;
        logic [ADDR_W-1:0] addr2;
    } result_pair_t;

    // Negative two's-complement sums clamp to zero.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_pair_fifo
// Description : Synchronous FIFO of result pairs; pushes while full and pops
//               while empty are ignored. Head is read combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module result_pair_fifo
    import npu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  result_pair_t     i_push_data,
    input  logic             i_pop,
    output result_pair_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    result_pair_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    // A full FIFO rejects the push even when a pop frees a slot this cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_writer
// Description : Buffers convolution result pairs and serialises each into two
//               backpressured writes on the feature-map memory.
//               Build option CONV_WB_RELU_EN clamps negative sums to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_writer
    import npu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = npu_pkg::ADDR_W,
    parameter int DATA_W = npu_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sum1,
    input  logic [DATA_W-1:0] i_sum2,
    input  logic [ADDR_W-1:0] i_dest_addr1,
    input  logic [ADDR_W-1:0] i_dest_addr2,
    output logic              o_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    input  logic              i_wr_ready,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [15:0]       o_pairs_written
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    result_pair_t      w_push_data;
    result_pair_t      w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [DATA_W-1:0] w_head_sum1;
    logic [DATA_W-1:0] w_head_sum2;

    wr_state_e         state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic [DATA_W-1:0] sum2_q, sum2_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       pairs_q, pairs_d;

    assign w_push_data = '{sum1: i_sum1, sum2: i_sum2, addr1: i_dest_addr1, addr2: i_dest_addr2};

    result_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (i_valid),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

`ifdef CONV_WB_RELU_EN
    assign w_head_sum1 = relu(w_head.sum1);
    assign w_head_sum2 = relu(w_head.sum2);
`else
    assign w_head_sum1 = w_head.sum1;
    assign w_head_sum2 = w_head.sum2;
`endif

    assign o_ready = !w_full;
    assign o_busy  = (w_count != '0) || (state_q != ST_IDLE);

    // A new pair is taken from IDLE, or straight after the second write completes.
    assign w_pop = !w_empty &&
                   ((state_q == ST_IDLE) || ((state_q == ST_WR_SECOND) && i_wr_ready));

    always_comb begin
        state_d    = state_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        addr2_d    = addr2_q;
        sum2_d     = sum2_q;
        pairs_d    = pairs_q;
        overflow_d = overflow_q || (i_valid && w_full);

        case (state_q)
            ST_IDLE: begin
                wr_en_d = 1'b0;
            end
            ST_WR_FIRST: begin
                if (i_wr_ready) begin
                    wr_addr_d = addr2_q;
                    wr_data_d = sum2_q;
                    state_d   = ST_WR_SECOND;
                end
            end
            ST_WR_SECOND: begin
                if (i_wr_ready) begin
                    pairs_d = pairs_q + 16'd1;
                    wr_en_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                wr_en_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (w_pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = w_head.addr1;
            wr_data_d = w_head_sum1;
            addr2_d   = w_head.addr2;
            sum2_d    = w_head_sum2;
            state_d   = ST_WR_FIRST;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            addr2_q    <= '0;
            sum2_q     <= '0;
            overflow_q <= 1'b0;
            pairs_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            addr2_q    <= addr2_d;
            sum2_q     <= sum2_d;
            overflow_q <= overflow_d;
            pairs_q    <= pairs_d;
        end
    end

    assign o_wr_en         = wr_en_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_overflow      = overflow_q;
    assign o_pairs_written = pairs_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_result_writer
// Description : Scoreboard bench for conv_result_writer; expected writes are
//               queued as pairs are accepted and popped by a write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_writer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_sum1 = '0;
    logic [7:0]  i_sum2 = '0;
    logic [9:0]  i_dest_addr1 = '0;
    logic [9:0]  i_dest_addr2 = '0;
    logic        i_wr_ready = 1'b0;
    logic        o_ready;
    logic        o_wr_en;
    logic [9:0]  o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_busy;
    logic        o_overflow;
    logic [15:0] o_pairs_written;

    conv_result_writer #(.DEPTH(4), .ADDR_W(10), .DATA_W(8)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_valid         (i_valid),
        .i_sum1          (i_sum1),
        .i_sum2          (i_sum2),
        .i_dest_addr1    (i_dest_addr1),
        .i_dest_addr2    (i_dest_addr2),
        .o_ready         (o_ready),
        .o_wr_en         (o_wr_en),
        .o_wr_addr       (o_wr_addr),
        .o_wr_data       (o_wr_data),
        .i_wr_ready      (i_wr_ready),
        .o_busy          (o_busy),
        .o_overflow      (o_overflow),
        .o_pairs_written (o_pairs_written)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        bit         last;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  exp_pairs = 0;
    bit  exp_ovf = 1'b0;

    function automatic logic [7:0] model_data(input logic [7:0] s);
`ifdef CONV_WB_RELU_EN
        return (s >= 8'd128) ? 8'd0 : s;
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one pair; the memory sees two writes for every accepted pair.
    task automatic send(input logic [7:0] s1, input logic [7:0] s2,
                        input logic [9:0] a1, input logic [9:0] a2, output bit acc);
        wr_t e;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_sum1 = s1; i_sum2 = s2; i_dest_addr1 = a1; i_dest_addr2 = a2;
        @(negedge i_clk);
        acc = o_ready;
        if (acc) begin
            e.addr = a1; e.data = model_data(s1); e.last = 1'b0; exp_q.push_back(e);
            e.addr = a2; e.data = model_data(s2); e.last = 1'b1; exp_q.push_back(e);
        end else begin
            exp_ovf = 1'b1;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    // Monitor: completed writes against the scoreboard, and output stability under stall.
    bit         prev_hold = 1'b0;
    logic [9:0] prev_addr;
    logic [7:0] prev_data;
    always @(negedge i_clk) begin
        wr_t e;
        if (i_rst_n) begin
            if (prev_hold) begin
                check("hold_wr_en", {31'd0, o_wr_en}, 32'd1);
                check("hold_addr", {22'd0, o_wr_addr}, {22'd0, prev_addr});
                check("hold_data", {24'd0, o_wr_data}, {24'd0, prev_data});
            end
            if (o_wr_en && i_wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none at %0t",
                             o_wr_addr, o_wr_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {22'd0, o_wr_addr}, {22'd0, e.addr});
                    check("wr_data", {24'd0, o_wr_data}, {24'd0, e.data});
                    if (e.last) exp_pairs++;
                end
            end
            prev_hold = o_wr_en && !i_wr_ready;
            prev_addr = o_wr_addr;
            prev_data = o_wr_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic check_drained(input string name);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_pairs"}, {16'd0, o_pairs_written}, exp_pairs);
        check({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        bit acc;
        bit acc_v[6];

        // Reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        check("rst_wr_addr", {22'd0, o_wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, o_wr_data}, 32'd0);
        check("rst_overflow", {31'd0, o_overflow}, 32'd0);
        check("rst_pairs", {16'd0, o_pairs_written}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_wr_ready = 1'b1;

        // Single pair: first write appears one edge after the accepting edge
        send(8'h12, 8'h34, 10'h040, 10'h041, acc);
        check("single_accept", {31'd0, acc}, 32'd1);
        @(negedge i_clk);
        check("lat_not_early", {31'd0, o_wr_en}, 32'd0);
        @(negedge i_clk);
        check("lat_first_en", {31'd0, o_wr_en}, 32'd1);
        check("lat_first_addr", {22'd0, o_wr_addr}, 32'h040);
        @(negedge i_clk);
        check("lat_second_addr", {22'd0, o_wr_addr}, 32'h041);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("single_pairs_const", {16'd0, o_pairs_written}, 32'd1);
        check_drained("single");

        // Backpressure in WR_FIRST; equal destination addresses
        @(posedge i_clk); #1;
        i_wr_ready = 1'b0;
        send(8'h55, 8'hAA, 10'h100, 10'h100, acc);
        repeat (5) @(posedge i_clk);
        #1 i_wr_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        check_drained("bp");

        // Fill and overflow with the memory stalled
        @(posedge i_clk); #1;
        i_wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h20 + i), 8'(8'h60 + i), 10'(10'h200 + 2 * i), 10'(10'h201 + 2 * i), acc);
            acc_v[i] = acc;
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_accept_%0d", i), {31'd0, acc_v[i]}, (i < 5) ? 32'd1 : 32'd0);
        end
        @(negedge i_clk);
        check("fill_overflow", {31'd0, o_overflow}, 32'd1);
        check("fill_ready_low", {31'd0, o_ready}, 32'd0);
        check("fill_busy", {31'd0, o_busy}, 32'd1);
        @(posedge i_clk); #1;
        i_wr_ready = 1'b1;
        repeat (14) @(posedge i_clk);
        @(negedge i_clk);
        check_drained("fill");
        check("fill_overflow_sticky", {31'd0, o_overflow}, 32'd1);

        // Back-to-back drain: six consecutive write cycles
        @(posedge i_clk); #1;
        i_wr_ready = 1'b0;
        send(8'h01, 8'h02, 10'h300, 10'h301, acc);
        send(8'h03, 8'h04, 10'h302, 10'h303, acc);
        send(8'h05, 8'h06, 10'h304, 10'h305, acc);
        i_wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check($sformatf("b2b_wr_en_%0d", i), {31'd0, o_wr_en}, 32'd1);
        end
        @(negedge i_clk);
        check("b2b_idle_after", {31'd0, o_wr_en}, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_drained("b2b");

        // ReLU directed pattern
        send(8'hF0, 8'h7F, 10'h3F0, 10'h3F1, acc);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        check_drained("relu");

        // Asynchronous reset while in WR_SECOND, with a pair still queued
        @(posedge i_clk); #1;
        i_wr_ready = 1'b0;
        send(8'h11, 8'h22, 10'h010, 10'h011, acc);
        send(8'h33, 8'h44, 10'h012, 10'h013, acc);
        i_wr_ready = 1'b1;
        @(posedge i_clk); #1;
        i_wr_ready = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_wr_en", {31'd0, o_wr_en}, 32'd0);
        check("arst_pairs", {16'd0, o_pairs_written}, 32'd0);
        check("arst_ready", {31'd0, o_ready}, 32'd1);
        check("arst_busy", {31'd0, o_busy}, 32'd0);
        check("arst_overflow", {31'd0, o_overflow}, 32'd0);
        exp_q.delete();
        exp_pairs = 0;
        exp_ovf = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_wr_ready = 1'b1;
        repeat (8) @(posedge i_clk);
        @(negedge i_clk);
        check_drained("arst");

        // Randomised traffic with random memory stalls
        for (int n = 0; n < 300; n++) begin
            @(posedge i_clk); #1;
            i_wr_ready = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 2) == 0) begin
                send(8'($urandom), 8'($urandom), 10'($urandom), 10'($urandom), acc);
            end
        end
        @(posedge i_clk); #1;
        i_wr_ready = 1'b1;
        repeat (30) @(posedge i_clk);
        @(negedge i_clk);
        check_drained("rand");
        check("rand_overflow", {31'd0, o_overflow}, {31'd0, exp_ovf});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
